fir_param: RTL and testbench
============================

Name: fir_param

Overview:
- Parametrised successor of the fixed 16-bit, 36-sample FIR engine.
- Memory-mapped FIR filter: the host loads samples and coefficients through an addr/din port, then pulses start on ctrl and polls bsy.
- Results are read back through the same addr/dout port.
- Adds runtime-loadable coefficients, configurable tap count, depth and width, output scaling, signed saturation with a sticky overflow flag, a done pulse, an abort command and a status word.

Parameters:
DATA_W, 16, sample/result/coefficient width (signed two's complement)
DEPTH, 36, number of samples and results
TAPS, 4, number of filter taps (>=1)
ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(TAPS)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
ADDR_W, 16, address port width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
ctrl  input  2  command: 00 nop, 01 start, 10 clear, 11 abort
we  input  1  write strobe for din at addr
din  input  DATA_W  write data
addr  input  ADDR_W  byte address; word index = addr[ADDR_W-1:2], addr[1:0] ignored
dout  output  DATA_W  registered read data
bsy  output  1  high while filtering
done  output  1  one-cycle pulse when a run completes
ovf  output  1  sticky saturation flag

Behaviour:
- Reset (rst=0, async): x[], h[], y[] all zero; dout=0, bsy=0, done=0, ovf=0; FSM=IDLE. Reset mid-run aborts immediately.
- Word map:
  - idx 0: read status {0.., ovf, bsy}; writes ignored.
  - idx 1..DEPTH: write x[idx-1]; read y[idx-1].
  - idx DEPTH+1..DEPTH+TAPS: write/read h[idx-DEPTH-1].
  - Other idx: writes ignored, reads 0.
- Writes: we=1 in IDLE stores din at the next edge. Writes while bsy=1 are ignored.
- Reads: allowed at any time. dout is updated at every edge from the current addr, so it is valid 1 cycle after addr changes.
- Math: y[n] = sat((sum_{k=0..TAPS-1} h[k]*x[n-k]) >>> SHIFT), with x[m]=0 for m<0.
  - Full-precision signed products, ACC_W accumulation.
  - Shift truncates toward -inf.
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets ovf.
- FSM states:
  - IDLE -> MAC on ctrl=01 (start edge E0). bsy=1, ovf cleared, n=0, k=0, acc=0.
  - MAC: one multiply-accumulate per cycle, k=0..TAPS-1 (TAPS cycles). -> STORE.
  - STORE: y[n] written. If n=DEPTH-1 -> IDLE with bsy=0 and done=1 on the same edge; else n++, k=0, acc=0, -> MAC.
- Run timing: bsy is high exactly DEPTH*(TAPS+1) cycles. done is high for exactly 1 cycle.
- ctrl=11 (abort) in MAC/STORE: -> IDLE next edge, bsy=0, no done.
  - y[] entries already stored are kept; the partial accumulation is discarded.
- ctrl=01 or 10 while busy: ignored.
- ctrl=10 in IDLE: x[], h[], y[] and ovf zeroed at the next edge.
- ctrl=01 and we=1 on the same IDLE cycle: the write lands, and the run uses the newly written value.
- y[] persists until the next run, clear or reset.

Test Plan:
1. Assert rst=0 mid-idle, then release -> dout=0, bsy=0, ovf=0; reads of idx 1, 36 and 40 return 0.
2. Identity filter: h={1,0,0,0}, SHIFT=0, x[i]=i+1, start -> bsy high exactly 180 cycles, single-cycle done; y[i]=i+1 for all 36 entries.
3. Moving sum: h={1,1,1,1}, all x=100 -> y[0]=100, y[1]=200, y[2]=300, y[3..35]=400.
4. Saturation: h[0]=0x7FFF, x[0]=0x7FFF, x[1]=0x8000, other h=0 -> y[0]=0x7FFF, y[1]=0x8000, ovf=1, status read=0x0002. A new start clears ovf.
5. Abort: ctrl=11 sampled 12 edges after the start edge -> bsy=0 next edge, done never pulses; y[0] and y[1] updated, y[2..35] keep their previous values.
6. Writes/clear while busy (we=1 to idx 1, ctrl=10 during a run) -> ignored, results match an undisturbed run. ctrl=10 in IDLE -> all x, h, y read back as 0.

Source files
------------

// File: rtl/fir_param.sv
// fir_param: memory-mapped FIR filter with loadable samples and coefficients.
// The host writes x[] and h[] through addr/din, pulses start on ctrl, polls
// bsy (or waits for done) and reads y[] back through addr/dout.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   ctrl  - command: 00 nop, 01 start, 10 clear, 11 abort
//   we    - write strobe for din at addr (honoured only when idle)
//   din   - write data
//   addr  - byte address; word index = addr[ADDR_W-1:2]
//   dout  - registered read data
//   bsy   - high while filtering
//   done  - one-cycle pulse when a run completes
//   ovf   - sticky saturation flag
module fir_param #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 36,
   parameter int unsigned TAPS   = 4,
   parameter int unsigned ACC_W  = 40,
   parameter int unsigned SHIFT  = 0,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ctrl,
   input  logic              we,
   input  logic [DATA_W-1:0] din,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dout,
   output logic              bsy,
   output logic              done,
   output logic              ovf
);

   localparam int unsigned NW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned KW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int unsigned PW = 2 * DATA_W;

   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE} state_t;

   state_t state_q, state_d;
   logic   done_d, bsy_d;

   logic signed [DATA_W-1:0] x_q [DEPTH];
   logic signed [DATA_W-1:0] h_q [TAPS];
   logic signed [DATA_W-1:0] y_q [DEPTH];

   logic        [NW-1:0]     n_q;
   logic        [KW-1:0]     k_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic        [31:0]       widx_c;
   logic        [DATA_W-1:0] rd_c;
   logic signed [DATA_W-1:0] x_sel_c, h_sel_c, sat_c;
   logic signed [PW-1:0]     prod_c;
   logic signed [ACC_W-1:0]  shifted_c;
   logic                     clamp_c;
   logic                     addr_unused_c;

   assign addr_unused_c = ^addr[1:0];

   // State register and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         bsy     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         bsy     <= bsy_d;
         done    <= done_d;
      end
   end

   // Next-state logic; abort wins over everything while busy
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctrl == CMD_START) state_d = S_MAC;
         end
         S_MAC: begin
            if (ctrl == CMD_ABORT)            state_d = S_IDLE;
            else if (k_q == KW'(TAPS - 1))    state_d = S_STORE;
         end
         S_STORE: begin
            if (ctrl == CMD_ABORT) begin
               state_d = S_IDLE;
            end else if (n_q == NW'(DEPTH - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_MAC;
            end
         end
         default: state_d = S_IDLE;
      endcase
      bsy_d = (state_d != S_IDLE);
   end

   // MAC operand fetch (x[m]=0 for m<0), product, scaling and saturation
   always_comb begin
      h_sel_c = h_q[k_q];
      x_sel_c = '0;
      if (32'(k_q) <= 32'(n_q)) x_sel_c = x_q[n_q - NW'(k_q)];
      prod_c    = PW'(h_sel_c) * PW'(x_sel_c);
      shifted_c = acc_q >>> SHIFT;
      clamp_c   = 1'b0;
      sat_c     = DATA_W'(shifted_c);
      if (shifted_c > SAT_MAX) begin
         sat_c   = SAT_MAX[DATA_W-1:0];
         clamp_c = 1'b1;
      end else if (shifted_c < SAT_MIN) begin
         sat_c   = SAT_MIN[DATA_W-1:0];
         clamp_c = 1'b1;
      end
   end

   // Word decode and read mux
   always_comb begin
      widx_c = 32'(addr[ADDR_W-1:2]);
      rd_c   = '0;
      if (widx_c == 32'd0)
         rd_c = {{(DATA_W-2){1'b0}}, ovf, bsy};
      else if (widx_c <= DEPTH)
         rd_c = y_q[NW'(widx_c - 32'd1)];
      else if (widx_c <= DEPTH + TAPS)
         rd_c = h_q[KW'(widx_c - DEPTH - 32'd1)];
   end

   // Storage, host writes, accumulation and result write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
         for (int i = 0; i < TAPS; i++) h_q[i] <= '0;
         n_q   <= '0;
         k_q   <= '0;
         acc_q <= '0;
         ovf   <= 1'b0;
         dout  <= '0;
      end else begin
         dout <= rd_c;
         case (state_q)
            S_IDLE: begin
               if (ctrl == CMD_CLEAR) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     x_q[i] <= '0;
                     y_q[i] <= '0;
                  end
                  for (int i = 0; i < TAPS; i++) h_q[i] <= '0;
                  ovf <= 1'b0;
               end else begin
                  // A write on the start cycle lands before the first MAC reads it
                  if (we && widx_c >= 32'd1 && widx_c <= DEPTH)
                     x_q[NW'(widx_c - 32'd1)] <= din;
                  else if (we && widx_c > DEPTH && widx_c <= DEPTH + TAPS)
                     h_q[KW'(widx_c - DEPTH - 32'd1)] <= din;
                  if (ctrl == CMD_START) begin
                     ovf   <= 1'b0;
                     n_q   <= '0;
                     k_q   <= '0;
                     acc_q <= '0;
                  end
               end
            end
            S_MAC: begin
               if (ctrl != CMD_ABORT) begin
                  acc_q <= acc_q + ACC_W'(prod_c);
                  k_q   <= k_q + KW'(1);
               end
            end
            S_STORE: begin
               if (ctrl != CMD_ABORT) begin
                  y_q[n_q] <= sat_c;
                  if (clamp_c) ovf <= 1'b1;
                  n_q   <= n_q + NW'(1);
                  k_q   <= '0;
                  acc_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param: directed self-checking bench for fir_param (default parameters).
module tb_fir_param;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 36;
   localparam int unsigned TAPS   = 4;
   localparam int unsigned ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        ctrl;
   logic              we;
   logic [DATA_W-1:0] din;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] dout;
   logic              bsy;
   logic              done;
   logic              ovf;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   fir_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .TAPS(TAPS),
      .ACC_W(40), .SHIFT(0), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .we(we), .din(din),
      .addr(addr), .dout(dout), .bsy(bsy), .done(done), .ovf(ovf)
   );

   task automatic wr(input int idx, input logic [DATA_W-1:0] d);
      @(negedge clk);
      addr = ADDR_W'(idx * 4);
      din  = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
   endtask

   task automatic rd(input int idx, output logic [DATA_W-1:0] d);
      @(negedge clk);
      addr = ADDR_W'(idx * 4);
      @(posedge clk);
      #1 d = dout;
   endtask

   // Leaves the bench on the negedge after the command edge
   task automatic pulse_cmd(input logic [1:0] c);
      @(negedge clk);
      ctrl = c;
      @(negedge clk);
      ctrl = 2'b00;
   endtask

   task automatic set_h(input logic [DATA_W-1:0] h0, input logic [DATA_W-1:0] h1,
                        input logic [DATA_W-1:0] h2, input logic [DATA_W-1:0] h3);
      wr(DEPTH + 1, h0);
      wr(DEPTH + 2, h1);
      wr(DEPTH + 3, h2);
      wr(DEPTH + 4, h3);
   endtask

   task automatic load_x_seq();
      for (int i = 0; i < DEPTH; i++) wr(i + 1, DATA_W'(i + 1));
   endtask

   // Counts bsy-high cycles and done pulses until bsy drops (bounded)
   task automatic wait_run(output int cyc, output int dn);
      cyc = 0;
      dn  = 0;
      while (bsy === 1'b1 && cyc < 1000) begin
         cyc++;
         if (done === 1'b1) dn++;
         @(negedge clk);
      end
      if (done === 1'b1) dn++;
      @(negedge clk);
      if (done === 1'b1) dn++;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] v;
      rst = 1'b0; ctrl = 2'b00; we = 1'b0; din = '0; addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wr(1, 16'd5);
      wr(DEPTH + 4, 16'd7);
      rd(DEPTH + 4, v);
      chk_cnt++;
      if (v !== 16'd7) $display("FAIL reset_pre_h3: got %0h want 7", v); else pass_cnt++;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk_cnt++;
      if ({dout, bsy, done, ovf} !== '0)
         $display("FAIL reset_outputs: dout=%0h bsy=%0b done=%0b ovf=%0b want 0", dout, bsy, done, ovf);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      rd(1, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL reset_idx1: got %0h want 0", v); else pass_cnt++;
      rd(DEPTH, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL reset_idx36: got %0h want 0", v); else pass_cnt++;
      rd(DEPTH + 4, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL reset_idx40: got %0h want 0", v); else pass_cnt++;
      rd(0, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL reset_status: got %0h want 0", v); else pass_cnt++;
   endtask

   task automatic test_identity();
      int cyc, dn;
      logic [DATA_W-1:0] v;
      set_h(16'd1, 16'd0, 16'd0, 16'd0);
      load_x_seq();
      pulse_cmd(2'b01);
      wait_run(cyc, dn);
      chk_cnt++;
      if (cyc != 180) $display("FAIL ident_bsy_cycles: got %0d want 180", cyc); else pass_cnt++;
      chk_cnt++;
      if (dn != 1) $display("FAIL ident_done_pulses: got %0d want 1", dn); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         rd(i + 1, v);
         chk_cnt++;
         if (v !== DATA_W'(i + 1)) $display("FAIL ident_y%0d: got %0h want %0h", i, v, i + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_moving_sum();
      int cyc, dn;
      logic [DATA_W-1:0] v, e;
      set_h(16'd1, 16'd1, 16'd1, 16'd1);
      for (int i = 0; i < DEPTH; i++) wr(i + 1, 16'd100);
      pulse_cmd(2'b01);
      wait_run(cyc, dn);
      for (int i = 0; i < DEPTH; i++) begin
         e = (i < 3) ? DATA_W'((i + 1) * 100) : 16'd400;
         rd(i + 1, v);
         chk_cnt++;
         if (v !== e) $display("FAIL msum_y%0d: got %0d want %0d", i, v, e); else pass_cnt++;
      end
   endtask

   task automatic test_saturation();
      int cyc, dn;
      logic [DATA_W-1:0] v;
      pulse_cmd(2'b10);
      set_h(16'h7FFF, 16'd0, 16'd0, 16'd0);
      wr(1, 16'h7FFF);
      wr(2, 16'h8000);
      pulse_cmd(2'b01);
      wait_run(cyc, dn);
      rd(1, v);
      chk_cnt++;
      if (v !== 16'h7FFF) $display("FAIL sat_pos: got %0h want 7fff", v); else pass_cnt++;
      rd(2, v);
      chk_cnt++;
      if (v !== 16'h8000) $display("FAIL sat_neg: got %0h want 8000", v); else pass_cnt++;
      rd(3, v);
      chk_cnt++;
      if (v !== 16'h0000) $display("FAIL sat_y2: got %0h want 0", v); else pass_cnt++;
      chk_cnt++;
      if (ovf !== 1'b1) $display("FAIL sat_ovf: got %0b want 1", ovf); else pass_cnt++;
      rd(0, v);
      chk_cnt++;
      if (v !== 16'h0002) $display("FAIL sat_status: got %0h want 2", v); else pass_cnt++;
      pulse_cmd(2'b01);
      chk_cnt++;
      if ({ovf, bsy} !== 2'b01) $display("FAIL sat_restart: ovf=%0b bsy=%0b want ovf=0 bsy=1", ovf, bsy);
      else pass_cnt++;
      wait_run(cyc, dn);
   endtask

   task automatic test_abort();
      int cyc, dn;
      logic [DATA_W-1:0] v, e;
      pulse_cmd(2'b10);
      set_h(16'd1, 16'd0, 16'd0, 16'd0);
      load_x_seq();
      pulse_cmd(2'b01);
      wait_run(cyc, dn);
      wr(DEPTH + 1, 16'd3);
      @(negedge clk);
      ctrl = 2'b01;
      @(negedge clk);
      ctrl = 2'b00;
      dn = 0;
      repeat (11) begin
         if (done === 1'b1) dn++;
         @(negedge clk);
      end
      chk_cnt++;
      if (bsy !== 1'b1) $display("FAIL abort_bsy_before: got %0b want 1", bsy); else pass_cnt++;
      ctrl = 2'b11;
      @(negedge clk);
      ctrl = 2'b00;
      chk_cnt++;
      if ({bsy, done} !== 2'b00) $display("FAIL abort_bsy_after: bsy=%0b done=%0b want 0 0", bsy, done);
      else pass_cnt++;
      repeat (5) begin
         if (done === 1'b1) dn++;
         @(negedge clk);
      end
      chk_cnt++;
      if (dn != 0) $display("FAIL abort_done: got %0d pulses want 0", dn); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         e = (i < 2) ? DATA_W'(3 * (i + 1)) : DATA_W'(i + 1);
         rd(i + 1, v);
         chk_cnt++;
         if (v !== e) $display("FAIL abort_y%0d: got %0d want %0d", i, v, e); else pass_cnt++;
      end
   endtask

   task automatic test_busy_ignore();
      int cyc, dn;
      logic [DATA_W-1:0] v;
      pulse_cmd(2'b01);
      @(negedge clk);
      addr = ADDR_W'(4);
      din  = 16'd999;
      we   = 1'b1;
      ctrl = 2'b10;
      @(negedge clk);
      we   = 1'b0;
      ctrl = 2'b00;
      wait_run(cyc, dn);
      chk_cnt++;
      if (dn != 1) $display("FAIL busy_done: got %0d pulses want 1", dn); else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         rd(i + 1, v);
         chk_cnt++;
         if (v !== DATA_W'(3 * (i + 1))) $display("FAIL busy_y%0d: got %0d want %0d", i, v, 3 * (i + 1));
         else pass_cnt++;
      end
   endtask

   task automatic test_clear();
      int cyc, dn;
      logic [DATA_W-1:0] v;
      pulse_cmd(2'b10);
      for (int i = 1; i <= DEPTH + TAPS; i++) begin
         rd(i, v);
         chk_cnt++;
         if (v !== 16'd0) $display("FAIL clear_idx%0d: got %0h want 0", i, v); else pass_cnt++;
      end
      wr(DEPTH + TAPS + 1, 16'h1234);
      rd(DEPTH + TAPS + 1, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL unmapped_idx: got %0h want 0", v); else pass_cnt++;
      wr(DEPTH + 1, 16'd1);
      @(negedge clk);
      ctrl = 2'b01;
      we   = 1'b1;
      addr = ADDR_W'(4);
      din  = 16'd55;
      @(negedge clk);
      ctrl = 2'b00;
      we   = 1'b0;
      wait_run(cyc, dn);
      rd(1, v);
      chk_cnt++;
      if (v !== 16'd55) $display("FAIL start_write_y0: got %0d want 55", v); else pass_cnt++;
      rd(2, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL cleared_x_y1: got %0d want 0", v); else pass_cnt++;
      rd(DEPTH, v);
      chk_cnt++;
      if (v !== 16'd0) $display("FAIL cleared_x_y35: got %0d want 0", v); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_moving_sum();
      test_saturation();
      test_abort();
      test_busy_ignore();
      test_clear();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
